// File: rtl/vec_data_mem.sv
// rtl/vec_data_mem.sv - M-stage data memory with combinational read and a valid/ready dump engine
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous active-low reset (FSM and dump outputs only; array is never cleared)
//   memWrite   write strobe from the M stage
//   addr       word address from the M stage
//   wrData     write data from the M stage
//   rdData     combinational read data (0 when addr is out of range)
//   dumpStart  single-cycle request to stream the whole array
//   dumpReady  consumer ready
//   dumpValid  dumpAddr/dumpData valid
//   dumpAddr   address of the presented word
//   dumpData   presented word
//   dumpBusy   dump in progress (LOAD, SEND, DONE)
//   dumpDone   one-cycle pulse after the final word handshake

module vec_data_mem #(
    parameter int DATA_W = 48,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData,
    input  logic              dumpStart,
    input  logic              dumpReady,
    output logic              dumpValid,
    output logic [ADDR_W-1:0] dumpAddr,
    output logic [DATA_W-1:0] dumpData,
    output logic              dumpBusy,
    output logic              dumpDone
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              addr_in_range;
    logic [IDX_W-1:0]  addr_idx;
    logic              wr_en;
    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] dump_addr_q;
    logic [DATA_W-1:0] dump_data_q;
    logic [DATA_W-1:0] load_word;

    assign addr_in_range = (addr < DEPTH_A);
    assign addr_idx      = addr[IDX_W-1:0];
    assign wr_en         = memWrite && addr_in_range;

    // Storage has no reset so contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_idx] <= wrData;
        end
    end

    // Read returns the pre-write word during a same-address write.
    assign rdData = addr_in_range ? mem[addr_idx] : '0;

    // A processor write landing on the word being loaded wins over the stale array value.
    assign load_word = (wr_en && (addr_idx == idx)) ? wrData : mem[idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dumpStart) begin
                        state <= LOAD;
                        idx   <= '0;
                    end
                end
                LOAD: begin
                    dump_data_q <= load_word;
                    dump_addr_q <= ADDR_W'(idx);
                    state       <= SEND;
                end
                SEND: begin
                    if (dumpReady) begin
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decode the state directly so reset clears them without waiting for a clock.
    assign dumpValid = (state == SEND);
    assign dumpBusy  = (state != IDLE);
    assign dumpDone  = (state == DONE);
    assign dumpAddr  = dump_addr_q;
    assign dumpData  = dump_data_q;

endmodule

// File: tb/tb_vec_data_mem.sv
// tb/tb_vec_data_mem.sv - self-checking bench for vec_data_mem
module tb_vec_data_mem;

    localparam int DATA_W = 48;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              memWrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrData;
    logic [DATA_W-1:0] rdData;
    logic              dumpStart;
    logic              dumpReady;
    logic              dumpValid;
    logic [ADDR_W-1:0] dumpAddr;
    logic [DATA_W-1:0] dumpData;
    logic              dumpBusy;
    logic              dumpDone;

    always #5 clk = ~clk;

    vec_data_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .memWrite(memWrite), .addr(addr), .wrData(wrData),
        .rdData(rdData), .dumpStart(dumpStart), .dumpReady(dumpReady),
        .dumpValid(dumpValid), .dumpAddr(dumpAddr), .dumpData(dumpData),
        .dumpBusy(dumpBusy), .dumpDone(dumpDone)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model: plain word array plus the set of words the bench has written.
    logic [DATA_W-1:0] model    [DEPTH];
    bit                known    [DEPTH];
    logic [DATA_W-1:0] exp_dump [DEPTH];
    bit                dumping  = 0;
    int                cur_word = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: apply the pending processor write to the model at the edge, then settle.
    task automatic cycle();
        @(posedge clk);
        if (memWrite && (int'(addr) < DEPTH)) begin
            model[addr[7:0]] = wrData;
            known[addr[7:0]] = 1'b1;
            // Words after the one on the dump channel have not been loaded yet.
            if (dumping && (int'(addr) > cur_word)) exp_dump[addr[7:0]] = wrData;
        end
        #1;
    endtask

    task automatic run_dump(input bit inject, input bit rnd_ready, input bit check_timing);
        int exp_idx   = 0;
        int stall     = 0;
        int cyc       = 0;
        int done_cnt  = 0;
        int done_cyc  = -1;
        bit restarted = 0;
        bit aborted   = 0;
        bit finished  = 0;
        for (int i = 0; i < DEPTH; i++) exp_dump[i] = model[i];
        dumping  = 1;
        cur_word = 0;
        memWrite = 0;
        dumpStart = 1;
        dumpReady = 1;
        cycle();
        dumpStart = 0;
        chk("busy_after_start", dumpBusy, 1);
        chk("valid_low_in_load", dumpValid, 0);
        while (cyc < 1500 && !finished && !aborted) begin
            memWrite  = 0;
            dumpStart = 0;
            dumpReady = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cur_word  = exp_idx;
            if (dumpDone) begin
                done_cnt++;
                done_cyc = cyc;
            end else if (done_cnt > 0) begin
                chk("busy_after_done", dumpBusy, 0);
                chk("valid_after_done", dumpValid, 0);
                finished = 1;
            end
            if (!finished && !dumpDone) chk("busy_during_dump", dumpBusy, 1);
            if (!finished && dumpValid) begin
                if (inject && exp_idx == 3 && stall < 5) begin
                    dumpReady = 0;
                    stall++;
                    if (stall == 1) begin memWrite = 1; addr = 16'd3;  wrData = 48'hAAAA; end
                    if (stall == 2) begin memWrite = 1; addr = 16'd10; wrData = 48'hBBBB; end
                    chk("stall_addr", dumpAddr, 3);
                    chk("stall_data", dumpData, exp_dump[3]);
                end
                if (inject && exp_idx == 50 && !restarted) begin
                    dumpStart = 1;
                    restarted = 1;
                end
                if (inject && exp_idx == 100) begin
                    #2 rst = 0;
                    #1;
                    chk("rst_valid_async", dumpValid, 0);
                    chk("rst_busy_async", dumpBusy, 0);
                    chk("rst_done_async", dumpDone, 0);
                    chk("rst_addr_async", dumpAddr, 0);
                    chk("rst_data_async", dumpData, 0);
                    @(posedge clk);
                    #3 rst = 1;
                    aborted = 1;
                end else if (dumpReady) begin
                    chk("dump_addr", dumpAddr, exp_idx);
                    chk("dump_data", dumpData, exp_dump[exp_idx]);
                    exp_idx++;
                end
            end
            if (!finished && !aborted) begin
                cycle();
                cyc++;
            end
        end
        memWrite  = 0;
        dumpStart = 0;
        dumpReady = 1;
        dumping   = 0;
        if (!aborted) begin
            chk("dump_no_timeout", finished, 1);
            chk("handshake_count", exp_idx, DEPTH);
            chk("done_pulses", done_cnt, 1);
            // Done is visible in the 513th cycle, i.e. after edge 2*DEPTH counted from the start edge.
            if (check_timing) chk("done_cycle", done_cyc, 2 * DEPTH);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        int a;
        rst       = 0;
        memWrite  = 0;
        addr      = 0;
        wrData    = 0;
        dumpStart = 0;
        dumpReady = 1;
        for (int i = 0; i < DEPTH; i++) known[i] = 0;
        #2;
        chk("reset_valid", dumpValid, 0);
        chk("reset_busy", dumpBusy, 0);
        chk("reset_done", dumpDone, 0);
        chk("reset_addr", dumpAddr, 0);
        chk("reset_data", dumpData, 0);
        #11 rst = 1;
        cycle();
        chk("idle_after_reset", dumpBusy, 0);

        // Random processor traffic, including out-of-range addresses.
        for (int n = 0; n < 80; n++) begin
            a        = int'($urandom_range(0, 319));
            d        = {16'($urandom), $urandom};
            addr     = 16'(a);
            wrData   = d;
            memWrite = 1'($urandom_range(0, 1));
            #1;
            if (a >= DEPTH) chk("rand_read_oor", rdData, 0);
            else if (known[a]) chk("rand_read", rdData, model[a]);
            cycle();
        end

        // Preload mem[i] = i.
        for (int i = 0; i < DEPTH; i++) begin
            memWrite = 1;
            addr     = 16'(i);
            wrData   = 48'(i);
            cycle();
        end

        // Read during write sees old word; new word visible next cycle.
        memWrite = 1;
        addr     = 16'h0005;
        wrData   = 48'h0000_1111_2222;
        #1;
        chk("rdw_old_word", rdData, 5);
        cycle();
        memWrite = 0;
        #1;
        chk("raw_new_word", rdData, 48'h0000_1111_2222);
        memWrite = 1;
        wrData   = 48'd5;
        cycle();

        // Out-of-range write is dropped and does not alias onto word 0.
        memWrite = 1;
        addr     = 16'h0100;
        wrData   = {16'($urandom) | 16'h1, $urandom};
        cycle();
        memWrite = 0;
        #1;
        chk("oor_read_zero", rdData, 0);
        addr = 16'h0000;
        #1;
        chk("oor_no_alias", rdData, model[0]);
        chk("model_word0", model[0], 0);

        // Full dump with ready held high.
        run_dump(0, 0, 1);

        // Dump with stall/writes at word 3, ignored restart at 50, reset at 100.
        run_dump(1, 0, 0);
        cycle();
        chk("no_resume_after_reset", dumpBusy, 0);
        cycle();
        chk("still_idle", dumpValid, 0);
        addr = 16'd3;   #1; chk("intact_3", rdData, 48'hAAAA);
        addr = 16'd10;  #1; chk("intact_10", rdData, 48'hBBBB);
        addr = 16'd100; #1; chk("intact_100", rdData, model[100]);
        addr = 16'd255; #1; chk("intact_255", rdData, 255);

        // Fresh dump restarts at address 0, with random back-pressure.
        run_dump(0, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vec_data_mem.md
Name: vec_data_mem

Overview:
- Data-memory responder on the far end of the processor's M-stage memory interface.
- Accepts the address, write data and write strobe that the processor drives, and returns the 48-bit read word in the same cycle.
- Contains a dump engine that streams memory contents word by word over a valid/ready channel to the testbench text writer. This replaces the processor-side txt tap.

Parameters:
- DATA_W, 48, word width; one 48-bit vector per address.
- ADDR_W, 16, processor address width.
- DEPTH, 256, number of words implemented; index = addr[$clog2(DEPTH)-1:0].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- memWrite  in  1  write strobe from M stage.
- addr  in  ADDR_W  word address from M stage.
- wrData  in  DATA_W  write data from M stage.
- rdData  out  DATA_W  read data to the M/W pipeline register.
- dumpStart  in  1  single-cycle request to begin a full dump.
- dumpReady  in  1  consumer ready.
- dumpValid  out  1  dumpAddr/dumpData valid.
- dumpAddr  out  ADDR_W  address of the presented word.
- dumpData  out  DATA_W  presented word.
- dumpBusy  out  1  high from the cycle after accepted dumpStart until IDLE is re-entered.
- dumpDone  out  1  one-cycle pulse after the final word handshake.

Behaviour:
- Storage: DEPTH x DATA_W array, not cleared by reset (contents persist).
- In range means addr < DEPTH.
- Write: on posedge, when memWrite=1 and addr is in range, mem[addr] <= wrData. Out-of-range writes are dropped silently.
- Read is combinational: rdData = mem[addr] when in range, else 0.
  - Zero latency, so the existing W-stage register captures it.
  - Read-during-write to the same address returns the old word that cycle; the new word is visible from the next cycle.
- Dump FSM states: IDLE, LOAD, SEND, DONE. Index register idx is $clog2(DEPTH) bits.
  - IDLE: dumpStart=1 -> LOAD, idx<=0. dumpStart is ignored in every other state.
  - LOAD: dumpData_reg <= mem[idx], dumpAddr <= zero-extended idx -> SEND.
  - SEND: dumpValid=1. dumpAddr/dumpData are held stable until dumpReady=1.
    - On handshake with idx==DEPTH-1 -> DONE.
    - Otherwise idx<=idx+1 -> LOAD.
  - DONE: dumpDone=1 for exactly one cycle -> IDLE.
- Throughput is one word per two cycles with dumpReady held high. A full dump is 2*DEPTH+1 cycles from the dumpStart edge to dumpDone.
- Processor reads and writes proceed unhindered during a dump; the write port has priority.
  - A write to a word already captured in SEND is not reflected in the presented dumpData.
  - A write to a word not yet loaded is reflected when it is loaded.
- dumpValid is low in IDLE, LOAD and DONE; dumpBusy=1 in LOAD, SEND and DONE.
- Reset (asynchronous, any state including mid-dump):
  - State -> IDLE, idx=0.
  - dumpValid=0, dumpDone=0, dumpBusy=0, dumpAddr=0, dumpData=0.
  - rdData follows the array combinationally.
  - No partial dump resumes after reset.

Test Plan:
- Write 0x0000_1111_2222 to addr 0x0005, then read addr 5 next cycle -> rdData=0x0000_1111_2222. Same-cycle read during the write -> previous contents.
- Write to addr 0x0100 (out of range, DEPTH=256), then read 0x0100 -> rdData=0, and mem[0x00] unchanged.
- Preload mem[i]=i, pulse dumpStart, dumpReady=1 -> 256 handshakes with dumpAddr 0..255 and dumpData 0..255. dumpDone pulses once, 513 cycles after the start edge; dumpBusy then falls.
- During SEND at idx 3, hold dumpReady=0 for 5 cycles -> dumpAddr=3 and dumpData=3 stay stable. A processor write of 0xAAAA to addr 3 is not reflected; a write of 0xBBBB to addr 10 appears in word 10 of the dump.
- Assert dumpStart again at idx 50 mid-dump -> ignored; the sequence continues at 51.
- Assert rst=0 at idx 100 -> dumpValid/dumpBusy drop immediately (asynchronously). After release, memory contents are intact, and a new dumpStart restarts at addr 0.
